// File: rtl/dm_mmio.sv
// -----------------------------------------------------------------------------
// dm_mmio: data-memory responder for the CPU data port.
//
// Combines a word-addressed RAM with a small memory-mapped I/O window:
//   MMIO_BASE + 0x00  CYCLE     read-only free-running cycle counter
//   MMIO_BASE + 0x04  GPIO      read/write, drives gpio_out
//   MMIO_BASE + 0x08  CON_TX    write-only, pushes a byte into the console FIFO
//   MMIO_BASE + 0x0C  CON_STAT  [7:0] level, [8] full, [9] empty, [10] OVF (sticky)
//                               write with bit 10 set clears OVF
// Any other MMIO offset reads 0 and ignores writes. Only dm_addr[31:16] is
// compared against MMIO_BASE; everything else goes to RAM, with the word
// index taken from dm_addr[log2(DEPTH_WORDS)+1:2] (higher bits alias).
//
// Build option:
//   DM_MMIO_CON_EN  defined   -> console FIFO, CON_TX, CON_STAT and OVF are built.
//                   undefined -> no FIFO; CON_TX writes ignored, CON_STAT reads
//                                32'h0000_0200, con_valid/con_data tied to 0.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous, active-low reset (deassertion synchronised by user)
//   dm_write    in   write strobe for dm_addr/dm_data_in
//   dm_addr     in   byte address, bits [1:0] ignored
//   dm_data_in  in   write data
//   dm_data_out out  registered read data (1-cycle latency, updated every cycle)
//   gpio_out    out  GPIO register
//   con_valid   out  console byte available (FIFO not empty)
//   con_data    out  console byte at FIFO head (0 when empty)
//   con_ready   in   console sink accepts con_data this cycle
//
// RAM contents are not cleared by reset.
// -----------------------------------------------------------------------------
module dm_mmio #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_write,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_data_in,
    output logic [31:0] dm_data_out,
    output logic [31:0] gpio_out,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // MMIO register offsets expressed as word offsets (dm_addr[15:2]).
    localparam logic [13:0] OffCycle   = 14'h0000;
    localparam logic [13:0] OffGpio    = 14'h0001;
    localparam logic [13:0] OffConTx   = 14'h0002;
    localparam logic [13:0] OffConStat = 14'h0003;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic          mmio_sel;
    logic [13:0]   mmio_word;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          gpio_we;
    logic          unused_addr_lsb;

    assign mmio_sel        = (dm_addr[31:16] == MMIO_BASE[31:16]);
    assign mmio_word       = dm_addr[15:2];
    assign ram_idx         = dm_addr[AW+1:2];
    assign ram_we          = dm_write && !mmio_sel;
    assign gpio_we         = dm_write && mmio_sel && (mmio_word == OffGpio);
    assign unused_addr_lsb = ^dm_addr[1:0];

    // -------------------------------------------------------------------------
    // RAM: no reset, read is combinational from the pre-edge contents so a
    // read-during-write to the same word returns the old value.
    // -------------------------------------------------------------------------
    logic [31:0] ram_q [DEPTH_WORDS];
    logic [31:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= dm_data_in;
        end
    end

    assign ram_rdata = ram_q[ram_idx];

    // -------------------------------------------------------------------------
    // Console FIFO and status
    // -------------------------------------------------------------------------
    logic [31:0] con_stat;

`ifdef DM_MMIO_CON_EN
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FifoDepthW = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic [7:0]    level_byte;

    assign fifo_full  = (level_q == FifoDepthW);
    assign fifo_empty = (level_q == '0);
    assign push_req   = dm_write && mmio_sel && (mmio_word == OffConTx);
    assign pop        = !fifo_empty && con_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when the sink drains the head.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && !push_ok;
    assign ovf_clr    = dm_write && mmio_sel && (mmio_word == OffConStat) && dm_data_in[10];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + (PW + 1)'(1);
            2'b01:   level_d = level_q - (PW + 1)'(1);
            default: level_d = level_q;
        endcase

        // Set has priority over a simultaneous clear.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= dm_data_in[7:0];
        end
    end

    // Level is reported in 8 bits; a completely full 256-entry FIFO shows 0
    // there, but the full flag disambiguates.
    assign level_byte = 8'(level_q);
    assign con_stat   = {21'b0, ovf_q, fifo_empty, fifo_full, level_byte};
    assign con_valid  = !fifo_empty;
    assign con_data   = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
`else
    logic unused_con_ready;

    assign unused_con_ready = con_ready;
    assign con_stat         = 32'h0000_0200;
    assign con_valid        = 1'b0;
    assign con_data         = 8'h00;
`endif

    // -------------------------------------------------------------------------
    // Cycle counter, GPIO and registered read data
    // -------------------------------------------------------------------------
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] rdata_q, rdata_d;

    // CYCLE is read-only: writes never reach cycle_d.
    assign cycle_d = cycle_q + 32'd1;
    assign gpio_d  = gpio_we ? dm_data_in : gpio_q;

    always_comb begin
        rdata_d = ram_rdata;
        if (mmio_sel) begin
            case (mmio_word)
                OffCycle:   rdata_d = cycle_q;
                OffGpio:    rdata_d = gpio_q;
                OffConStat: rdata_d = con_stat;
                default:    rdata_d = 32'h0000_0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= 32'h0000_0000;
            gpio_q  <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
        end else begin
            cycle_q <= cycle_d;
            gpio_q  <= gpio_d;
            rdata_q <= rdata_d;
        end
    end

    assign dm_data_out = rdata_q;
    assign gpio_out    = gpio_q;

endmodule

// File: tb/tb_dm_mmio.sv
// -----------------------------------------------------------------------------
// tb_dm_mmio: self-checking bench for dm_mmio.
// Keeps a behavioural model (RAM as an associative array, console FIFO as a
// byte queue, cycle count, GPIO value) and compares every observed read and
// output against it and against fixed expectations for directed scenarios.
// Works with and without DM_MMIO_CON_EN.
// -----------------------------------------------------------------------------
module tb_dm_mmio;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned FDEPTH = 8;

`ifdef DM_MMIO_CON_EN
    localparam bit ConEn = 1'b1;
`else
    localparam bit ConEn = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        dm_write   = 1'b0;
    logic [31:0] dm_addr    = 32'h0;
    logic [31:0] dm_data_in = 32'h0;
    logic        con_ready  = 1'b0;
    logic [31:0] dm_data_out;
    logic [31:0] gpio_out;
    logic        con_valid;
    logic [7:0]  con_data;

    always #5 clk = ~clk;

    dm_mmio #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (32'hFFFF_0000),
        .FIFO_DEPTH  (FDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dm_write    (dm_write),
        .dm_addr     (dm_addr),
        .dm_data_in  (dm_data_in),
        .dm_data_out (dm_data_out),
        .gpio_out    (gpio_out),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model state
    logic [31:0] ram_m [int];
    logic [31:0] gpio_m = 32'h0;
    logic [31:0] cyc_m  = 32'h0;
    logic [7:0]  q_m [$];
    logic        ovf_m  = 1'b0;

    function automatic logic [31:0] stat_m();
        if (!ConEn) return 32'h0000_0200;
        return {21'b0, ovf_m, (q_m.size() == 0), (q_m.size() == FDEPTH), 8'(q_m.size())};
    endfunction

    function automatic logic [7:0] head_m();
        if (q_m.size() == 0) return 8'h00;
        return q_m[0];
    endfunction

    // One bus cycle: drive inputs, predict the read, clock, update the model.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic rdy, output logic [31:0] got,
                          output logic [31:0] exp, output bit known);
        bit         mmio;
        int         word;
        int         idx;
        bit         pop_m, push_m, set_m, clr_m;
        logic [7:0] tmp;
        dm_write   = w;
        dm_addr    = a;
        dm_data_in = d;
        con_ready  = rdy;
        mmio  = (a[31:16] == 16'hFFFF);
        word  = int'(a[15:2]);
        idx   = int'((a >> 2) % DEPTH);
        known = 1'b1;
        exp   = 32'h0;
        if (mmio) begin
            if (word == 0) exp = cyc_m;
            else if (word == 1) exp = gpio_m;
            else if (word == 3) exp = stat_m();
            else exp = 32'h0;
        end else if (ram_m.exists(idx)) begin
            exp = ram_m[idx];
        end else begin
            known = 1'b0;
        end
        pop_m  = ConEn && (q_m.size() > 0) && rdy;
        push_m = ConEn && w && mmio && (word == 2);
        set_m  = push_m && (q_m.size() == FDEPTH) && !pop_m;
        clr_m  = w && mmio && (word == 3) && d[10];
        @(posedge clk);
        if (rst) begin
            cyc_m = cyc_m + 32'd1;
            if (!mmio && w) ram_m[idx] = d;
            if (mmio && w && word == 1) gpio_m = d;
            if (pop_m) tmp = q_m.pop_front();
            if (push_m && !set_m) q_m.push_back(d[7:0]);
            if (set_m) ovf_m = 1'b1;
            else if (clr_m) ovf_m = 1'b0;
        end
        #1;
        got = dm_data_out;
    endtask

    task automatic model_reset();
        gpio_m = 32'h0;
        cyc_m  = 32'h0;
        q_m.delete();
        ovf_m  = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] got, exp;
        bit known;
        rst = 1'b0;
        dm_write = 1'b0;
        con_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (dm_data_out !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", dm_data_out);
        else n_pass++;
        n_total++;
        if (gpio_out !== 32'h0) $display("FAIL reset_gpio got=%h exp=0", gpio_out);
        else n_pass++;
        n_total++;
        if (con_valid !== 1'b0 || con_data !== 8'h00)
            $display("FAIL reset_con got=%b/%h exp=0/00", con_valid, con_data);
        else n_pass++;
        rst = 1'b1;
        access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0) $display("FAIL reset_cycle_first got=%h exp=0", got);
        else n_pass++;
    endtask

    task automatic test_cycle();
        logic [31:0] got, exp, c0, c5;
        bit known;
        access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, c0, exp, known);
        n_total++;
        if (c0 !== exp) $display("FAIL cycle_model got=%h exp=%h", c0, exp);
        else n_pass++;
        repeat (4) access(1'b0, 32'hFFFF_0010, 32'h0, 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, c5, exp, known);
        n_total++;
        if (c5 - c0 !== 32'd5) $display("FAIL cycle_delta got=%0d exp=5", c5 - c0);
        else n_pass++;
        access(1'b1, 32'hFFFF_0000, 32'h0, 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== c5 + 32'd2) $display("FAIL cycle_write_ignored got=%h exp=%h", got, c5 + 32'd2);
        else n_pass++;
    endtask

    task automatic test_ram();
        logic [31:0] got, exp;
        bit known;
        access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, got, exp, known);
        access(1'b0, 32'h0000_0010, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'hDEAD_BEEF) $display("FAIL ram_readback got=%h exp=deadbeef", got);
        else n_pass++;
        access(1'b0, 32'h0000_1010, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'hDEAD_BEEF) $display("FAIL ram_alias got=%h exp=deadbeef", got);
        else n_pass++;
        // Write through the alias while reading: old value comes back.
        access(1'b1, 32'h0000_1012, 32'h1234_5678, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'hDEAD_BEEF) $display("FAIL ram_rdw got=%h exp=deadbeef", got);
        else n_pass++;
        access(1'b0, 32'h0000_0010, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h1234_5678) $display("FAIL ram_alias_write got=%h exp=12345678", got);
        else n_pass++;
        // Back-to-back writes then reads
        for (int i = 0; i < 4; i++)
            access(1'b1, 32'h0000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, got, exp, known);
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 32'h0000_0100 + 32'(4 * i), 32'h0, 1'b0, got, exp, known);
            n_total++;
            if (got !== 32'hA000_0000 + 32'(i))
                $display("FAIL ram_b2b[%0d] got=%h exp=%h", i, got, 32'hA000_0000 + 32'(i));
            else n_pass++;
        end
    endtask

    task automatic test_gpio();
        logic [31:0] got, exp;
        bit known;
        access(1'b1, 32'hFFFF_0004, 32'h0000_00A5, 1'b0, got, exp, known);
        n_total++;
        if (gpio_out !== 32'h0000_00A5) $display("FAIL gpio_out got=%h exp=000000a5", gpio_out);
        else n_pass++;
        n_total++;
        if (got !== 32'h0) $display("FAIL gpio_rdw got=%h exp=0", got);
        else n_pass++;
        access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0000_00A5) $display("FAIL gpio_read got=%h exp=000000a5", got);
        else n_pass++;
        access(1'b1, 32'hFFFF_0020, 32'hFFFF_FFFF, 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_0020, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0 || gpio_out !== 32'h0000_00A5)
            $display("FAIL unmapped got=%h gpio=%h exp=0/000000a5", got, gpio_out);
        else n_pass++;
    endtask

`ifdef DM_MMIO_CON_EN
    task automatic test_console();
        logic [31:0] got, exp;
        logic [7:0]  eb;
        bit known;
        for (int i = 0; i < 9; i++)
            access(1'b1, 32'hFFFF_0008, 32'h41 + 32'(i), 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_000C, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0000_0508) $display("FAIL con_stat_ovf got=%h exp=00000508", got);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            eb = 8'h41 + 8'(i);
            n_total++;
            if (con_valid !== 1'b1 || con_data !== eb)
                $display("FAIL con_drain[%0d] got=%b/%h exp=1/%h", i, con_valid, con_data, eb);
            else n_pass++;
            access(1'b0, 32'hFFFF_0010, 32'h0, 1'b1, got, exp, known);
        end
        n_total++;
        if (con_valid !== 1'b0) $display("FAIL con_empty got=%b exp=0", con_valid);
        else n_pass++;
        access(1'b1, 32'hFFFF_000C, 32'h0000_0400, 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_000C, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0000_0200) $display("FAIL con_ovf_clear got=%h exp=00000200", got);
        else n_pass++;
        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 8; i++)
            access(1'b1, 32'hFFFF_0008, 32'h61 + 32'(i), 1'b0, got, exp, known);
        access(1'b1, 32'hFFFF_0008, 32'h5A, 1'b1, got, exp, known);
        access(1'b0, 32'hFFFF_000C, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0000_0108) $display("FAIL con_full_pushpop got=%h exp=00000108", got);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            eb = (i == 7) ? 8'h5A : 8'h62 + 8'(i);
            n_total++;
            if (con_valid !== 1'b1 || con_data !== eb)
                $display("FAIL con_drain2[%0d] got=%b/%h exp=1/%h", i, con_valid, con_data, eb);
            else n_pass++;
            access(1'b0, 32'hFFFF_0010, 32'h0, 1'b1, got, exp, known);
        end
    endtask
`else
    task automatic test_console_disabled();
        logic [31:0] got, exp;
        bit known;
        access(1'b1, 32'hFFFF_0008, 32'h41, 1'b1, got, exp, known);
        n_total++;
        if (con_valid !== 1'b0 || con_data !== 8'h00)
            $display("FAIL con_dis_valid got=%b/%h exp=0/00", con_valid, con_data);
        else n_pass++;
        for (int i = 0; i < 10; i++)
            access(1'b1, 32'hFFFF_0008, 32'h42 + 32'(i), 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_000C, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'h0000_0200) $display("FAIL con_dis_stat got=%h exp=00000200", got);
        else n_pass++;
        n_total++;
        if (con_valid !== 1'b0) $display("FAIL con_dis_after got=%b exp=0", con_valid);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] got, exp, a, d;
        bit known;
        int sel;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            a = $urandom;
            if (sel < 4) begin
                a = {16'hFFFF, 12'h000, sel[1:0], a[1:0]};
            end else if (sel == 4) begin
                a = {16'hFFFF, 14'($urandom_range(4, 16383)), a[1:0]};
            end else begin
                a[11:2] = 10'($urandom_range(0, 15));
                if (a[31:16] == 16'hFFFF) a[16] = 1'b0;
            end
            d = $urandom;
            access(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)), got, exp, known);
            if (known) begin
                n_total++;
                if (got !== exp) $display("FAIL rnd_read[%0d] addr=%h got=%h exp=%h", n, a, got, exp);
                else n_pass++;
            end
            n_total++;
            if (gpio_out !== gpio_m) $display("FAIL rnd_gpio[%0d] got=%h exp=%h", n, gpio_out, gpio_m);
            else n_pass++;
            n_total++;
            if (con_valid !== (q_m.size() != 0) || con_data !== head_m())
                $display("FAIL rnd_con[%0d] got=%b/%h exp=%b/%h", n, con_valid, con_data,
                         (q_m.size() != 0), head_m());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp, ram_exp;
        bit known;
        access(1'b1, 32'hFFFF_0004, 32'h1357_9BDF, 1'b0, got, exp, known);
        access(1'b1, 32'hFFFF_0008, 32'h77, 1'b0, got, exp, known);
        access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, got, exp, known);
        ram_exp = ram_m[4];
        dm_write = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (gpio_out !== 32'h0 || dm_data_out !== 32'h0)
            $display("FAIL midreset_async got=%h/%h exp=0/0", gpio_out, dm_data_out);
        else n_pass++;
        n_total++;
        if (con_valid !== 1'b0 || con_data !== 8'h00)
            $display("FAIL midreset_con got=%b/%h exp=0/00", con_valid, con_data);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        access(1'b0, 32'h0000_0010, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== ram_exp) $display("FAIL midreset_ram got=%h exp=%h", got, ram_exp);
        else n_pass++;
        access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, got, exp, known);
        n_total++;
        if (got !== 32'd1) $display("FAIL midreset_cycle got=%h exp=1", got);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_ram();
        test_gpio();
`ifdef DM_MMIO_CON_EN
        test_console();
`else
        test_console_disabled();
`endif
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
